// File: rtl/updown_cnt_pkg.sv
// Shared constants and helpers for the up/down counter and its prescaler.
package updown_cnt_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Wide enough to hold any WIDTH+1 intermediate for WIDTH up to 32.
    localparam int CNT_X_W = 33;

    function automatic logic [CNT_X_W-1:0] clamp_load(input logic [CNT_X_W-1:0] val,
                                                      input logic [CNT_X_W-1:0] max);
        return (val > max) ? max : val;
    endfunction

    function automatic int pre_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/updown_prescaler.sv
// Free-running divider: step fires on the enabled cycle where pre reaches PRESCALE-1.
// Step is combinational from the pre register; clr zeroes pre and wins over en; no backpressure.
module updown_prescaler
    import updown_cnt_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic step
);

    localparam int              PRE_W    = pre_width(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] r_pre;
    logic             w_last;

    assign w_last = (r_pre == PRE_LAST);
    assign step   = en & w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
        end else if (clr) begin
            r_pre <= '0;
        end else if (en) begin
            r_pre <= w_last ? '0 : r_pre + 1'b1;
        end
    end

endmodule

// File: rtl/param_updown_counter.sv
// Prescaled up/down counter with modulo wrap (UPDOWN_CNT_SATURATE_EN: saturate), load and tc.
// count/tick/tc register on the edge consuming a step; load > step > hold; no backpressure.
module param_updown_counter
    import updown_cnt_pkg::*;
#(
    parameter int                 WIDTH    = 4,
    parameter logic [CNT_X_W-1:0] MOD_MAX  = (33'd1 << WIDTH) - 33'd1,
    parameter int                 PRESCALE = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH:0] MAX_X = MOD_MAX[WIDTH:0];

    logic [WIDTH-1:0]   r_count;
    logic               r_tick;
    logic               r_tc;
    logic               w_step;
    logic [WIDTH:0]     w_cnt_x;
    logic [WIDTH:0]     w_next;
    logic               w_hit;
    logic [CNT_X_W-1:0] w_load_x;
    logic [CNT_X_W-1:0] w_load_clamped;

    updown_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (load),
        .step  (w_step)
    );

    assign w_cnt_x        = {1'b0, r_count};
    assign w_load_x       = {{(CNT_X_W-WIDTH){1'b0}}, load_val};
    assign w_load_clamped = clamp_load(w_load_x, MOD_MAX);

    // Next value on a step; w_hit marks wrap (or arrival at / stay on a saturation bound).
    always_comb begin
        w_next = w_cnt_x;
        w_hit  = 1'b0;
        if (up_down == DIR_UP) begin
            if (w_cnt_x >= MAX_X) begin
`ifdef UPDOWN_CNT_SATURATE_EN
                w_next = MAX_X;
`else
                w_next = '0;
`endif
                w_hit  = 1'b1;
            end else begin
                w_next = w_cnt_x + 1'b1;
`ifdef UPDOWN_CNT_SATURATE_EN
                w_hit  = ((w_cnt_x + 1'b1) == MAX_X);
`endif
            end
        end else begin
            if (w_cnt_x == '0) begin
`ifdef UPDOWN_CNT_SATURATE_EN
                w_next = '0;
`else
                w_next = MAX_X;
`endif
                w_hit  = 1'b1;
            end else begin
                w_next = w_cnt_x - 1'b1;
`ifdef UPDOWN_CNT_SATURATE_EN
                w_hit  = (w_cnt_x == {{WIDTH{1'b0}}, 1'b1});
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tick  <= 1'b0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped[WIDTH-1:0];
            r_tick  <= 1'b0;
            r_tc    <= 1'b0;
        end else if (w_step) begin
            r_count <= w_next[WIDTH-1:0];
            r_tick  <= 1'b1;
            r_tc    <= w_hit;
        end else begin
            r_tick  <= 1'b0;
            r_tc    <= 1'b0;
        end
    end

    assign count = r_count;
    assign tick  = r_tick;
    assign tc    = r_tc;

endmodule
